// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD text path: the sequencer state
// encoding, the HD44780-style command bytes, and the lcdFSM state encoding.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_LINE1  = 8'h80;  // set DDRAM address 0x00
  localparam logic [7:0] LCD_CMD_LINE2  = 8'hC0;  // set DDRAM address 0x40
  localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;  // clear display
  localparam logic [7:0] LCD_CHAR_BLANK = 8'h20;  // ASCII space

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    REQ  = 3'd2,
    HOLD = 3'd3,
    DONE = 3'd4
  } lcd_seq_statetype;

  typedef enum logic [2:0] {
    FSM_POWERUP = 3'd0,
    FSM_BOOT    = 3'd1,
    FSM_IDLE    = 3'd2,
    FSM_SET     = 3'd3,
    FSM_WRITE   = 3'd4,
    FSM_OFF     = 3'd5
  } lcd_fsm_statetype;

endpackage

// File: rtl/lcd_char_buffer.sv
// Character frame buffer: DEPTH x 8 register file with synchronous write,
// combinational (read-before-write) read, and reset to the blank character.
module lcd_char_buffer
  import lcd_pkg::*;
#(
  parameter int         DEPTH = 32,
  parameter int         AW    = 5,
  parameter logic [7:0] BLANK = LCD_CHAR_BLANK
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  // Storage: blank every entry on reset, otherwise accept upstream writes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= BLANK;
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A same-cycle write to the read address is not visible until the next cycle.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Repaints a 2-line LCD from a character buffer by streaming the line-1
// address, line-1 characters, line-2 address and line-2 characters through
// the lcdFSM data_ready/busy handshake. All outputs are registered.
module lcd_text_sequencer
  import lcd_pkg::*;
#(
  parameter int         LINE_LEN  = 16,
  parameter logic [7:0] LINE1_CMD = LCD_CMD_LINE1,
  parameter logic [7:0] LINE2_CMD = LCD_CMD_LINE2,
  parameter logic [7:0] BLANK     = LCD_CHAR_BLANK,
  localparam int        AW        = $clog2(2*LINE_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          refresh,
  input  logic          lcd_busy,
  output logic          data_ready,
  output logic [7:0]    d_out,
  output logic          rs_out,
  output logic          active,
  output logic          done
);

  // Sequence index covers two address commands plus 2*LINE_LEN characters.
  localparam int             IW        = $clog2(2*LINE_LEN + 2);
  localparam logic [IW-1:0]  IDX_LINE2 = IW'(LINE_LEN + 1);
  localparam logic [IW-1:0]  IDX_LAST  = IW'(2*LINE_LEN + 1);

  lcd_seq_statetype state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             pending_q, pending_d;
  logic             data_ready_q, data_ready_d;
  logic [7:0]       d_out_q, d_out_d;
  logic             rs_out_q, rs_out_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  logic [AW-1:0]    rd_addr_s;
  logic [7:0]       rd_data_s;
  logic [7:0]       seq_byte_s;
  logic             seq_rs_s;

  lcd_char_buffer #(
    .DEPTH (2*LINE_LEN),
    .AW    (AW),
    .BLANK (BLANK)
  ) u_buf (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr_s),
    .rd_data_o (rd_data_s)
  );

  // Map the sequence index to the byte to send and its register-select bit.
  always_comb begin
    rd_addr_s  = AW'(idx_q - IW'(2));
    seq_byte_s = rd_data_s;
    seq_rs_s   = 1'b1;
    if (idx_q == IW'(0)) begin
      seq_byte_s = LINE1_CMD;
      seq_rs_s   = 1'b0;
    end else if (idx_q <= IW'(LINE_LEN)) begin
      rd_addr_s  = AW'(idx_q - IW'(1));
    end else if (idx_q == IDX_LINE2) begin
      seq_byte_s = LINE2_CMD;
      seq_rs_s   = 1'b0;
    end else begin
      rd_addr_s  = AW'(idx_q - IW'(2));
    end
  end

  // Next-state and registered-output logic for the handshake sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    data_ready_d = data_ready_q;
    d_out_d      = d_out_q;
    rs_out_d     = rs_out_q;
    active_d     = active_q;
    done_d       = 1'b0;

    // Requests arriving mid-refresh collapse into a single queued repaint.
    if (refresh && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      IDLE: begin
        if (refresh || pending_q) begin
          state_d   = LOAD;
          idx_d     = IW'(0);
          active_d  = 1'b1;
          pending_d = 1'b0;
        end else begin
          state_d   = IDLE;
        end
      end
      LOAD: begin
        // Busy high here also covers the LCD power-up interval.
        if (!lcd_busy) begin
          state_d      = REQ;
          d_out_d      = seq_byte_s;
          rs_out_d     = seq_rs_s;
          data_ready_d = 1'b1;
        end else begin
          state_d      = LOAD;
        end
      end
      REQ: begin
        // Request is held until lcdFSM leaves boot/idle and raises busy.
        if (lcd_busy) begin
          state_d      = HOLD;
          data_ready_d = 1'b0;
        end else begin
          state_d      = REQ;
        end
      end
      HOLD: begin
        if (!lcd_busy) begin
          if (idx_q == IDX_LAST) begin
            state_d  = DONE;
            done_d   = 1'b1;
            active_d = 1'b0;
          end else begin
            state_d  = LOAD;
            idx_d    = idx_q + IW'(1);
          end
        end else begin
          state_d = HOLD;
        end
      end
      DONE: begin
        if (pending_q) begin
          state_d   = LOAD;
          idx_d     = IW'(0);
          active_d  = 1'b1;
          pending_d = refresh;
        end else begin
          state_d   = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        data_ready_d = 1'b0;
        active_d     = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= IW'(0);
      pending_q    <= 1'b0;
      data_ready_q <= 1'b0;
      d_out_q      <= 8'h00;
      rs_out_q     <= 1'b0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      data_ready_q <= data_ready_d;
      d_out_q      <= d_out_d;
      rs_out_q     <= rs_out_d;
      active_q     <= active_d;
      done_q       <= done_d;
    end
  end

  assign data_ready = data_ready_q;
  assign d_out      = d_out_q;
  assign rs_out     = rs_out_q;
  assign active     = active_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Directed bench for lcd_text_sequencer against a behavioural lcdFSM model
// (power-up busy, boot with busy low, then set/write/off per transaction).
module tb_lcd_text_sequencer;
  import lcd_pkg::*;

  localparam int PWR_CYC  = 20;
  localparam int BOOT_CYC = 5;
  localparam int PH_CYC   = 2;
  localparam int BUDGET   = 1500;

  logic       clk = 1'b0;
  logic       reset, wr_en, refresh, lcd_busy;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       data_ready, rs_out, active, done;
  logic [7:0] d_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_buf [32];
  logic [8:0] log_q [$];
  int         done_cnt     = 0;
  int         stab_samples = 0;
  int         stab_viol    = 0;

  lcd_fsm_statetype lst;
  int               lcnt;
  logic [7:0]       cap_d;
  logic             cap_rs;

  always #5 clk = ~clk;

  lcd_text_sequencer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .refresh(refresh), .lcd_busy(lcd_busy),
    .data_ready(data_ready), .d_out(d_out), .rs_out(rs_out),
    .active(active), .done(done)
  );

  // Behavioural lcdFSM: logs each accepted transaction as {rs, byte}.
  always @(posedge clk) begin
    if (reset) begin
      lst <= FSM_POWERUP; lcnt <= 0; lcd_busy <= 1'b1;
    end else begin
      case (lst)
        FSM_POWERUP: if (lcnt == PWR_CYC-1) begin lst <= FSM_BOOT; lcnt <= 0; lcd_busy <= 1'b0; end
                     else lcnt <= lcnt + 1;
        FSM_BOOT:    if (lcnt == BOOT_CYC-1) begin lst <= FSM_IDLE; lcnt <= 0; end
                     else lcnt <= lcnt + 1;
        FSM_IDLE:    if (data_ready === 1'b1) begin
                       lst <= FSM_SET; lcnt <= 0; lcd_busy <= 1'b1;
                       cap_d <= d_out; cap_rs <= rs_out;
                       log_q.push_back({rs_out, d_out});
                     end
        FSM_SET:     if (lcnt == PH_CYC-1) begin lst <= FSM_WRITE; lcnt <= 0; end else lcnt <= lcnt + 1;
        FSM_WRITE:   if (lcnt == PH_CYC-1) begin lst <= FSM_OFF; lcnt <= 0; end else lcnt <= lcnt + 1;
        FSM_OFF:     if (lcnt == PH_CYC-1) begin lst <= FSM_IDLE; lcnt <= 0; lcd_busy <= 1'b0; end
                     else lcnt <= lcnt + 1;
        default:     lst <= FSM_POWERUP;
      endcase
    end
  end

  // Monitors: done pulses and d_out/rs_out stability during set/write/off.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (reset === 1'b0 && (lst == FSM_SET || lst == FSM_WRITE || lst == FSM_OFF)) begin
      stab_samples++;
      if (d_out !== cap_d || rs_out !== cap_rs) stab_viol++;
    end
  end

  function automatic logic [8:0] exp_word(input int j);
    if (j == 0)       return 9'h080;
    else if (j <= 16) return {1'b1, exp_buf[j-1]};
    else if (j == 17) return 9'h0C0;
    else              return {1'b1, exp_buf[j-2]};
  endfunction

  task automatic pulse_refresh();
    refresh = 1'b1; @(negedge clk); refresh = 1'b0;
  endtask

  task automatic write_char(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d; exp_buf[a] = d;
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; refresh = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    repeat (3) @(negedge clk);
    n_cmp++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b want 0", data_ready); end
    n_cmp++; if (d_out !== 8'h00)     begin n_fail++; $display("FAIL reset_d_out: got %h want 00", d_out); end
    n_cmp++; if (rs_out !== 1'b0)     begin n_fail++; $display("FAIL reset_rs_out: got %b want 0", rs_out); end
    n_cmp++; if (active !== 1'b0)     begin n_fail++; $display("FAIL reset_active: got %b want 0", active); end
    n_cmp++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
  endtask

  task automatic test_powerup();
    bit ok; bit early; int n;
    log_q.delete(); done_cnt = 0; early = 1'b0; n = 0;
    pulse_refresh();
    n_cmp++; if (active !== 1'b1) begin n_fail++; $display("FAIL pwr_active: got %b want 1", active); end
    while (lst == FSM_POWERUP && n < 100) begin
      if (data_ready !== 1'b0) early = 1'b1;
      @(negedge clk); n++;
    end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL pwr_data_ready_early: got 1 want 0"); end
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL pwr_done_timeout: got none want done"); end
    repeat (2) @(negedge clk);
    n_cmp++; if (log_q.size() != 34) begin n_fail++; $display("FAIL pwr_count: got %0d want 34", log_q.size()); end
    else begin
      n_cmp++; if (log_q[0] !== 9'h080)  begin n_fail++; $display("FAIL pwr_first: got %h want 080", log_q[0]); end
      n_cmp++; if (log_q[33] !== 9'h120) begin n_fail++; $display("FAIL pwr_last: got %h want 120", log_q[33]); end
    end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL pwr_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_full_refresh();
    bit ok;
    write_char(0, 8'h48); write_char(1, 8'h45); write_char(2, 8'h4C);
    write_char(3, 8'h4C); write_char(4, 8'h4F);
    write_char(16, 8'h57); write_char(17, 8'h4F); write_char(18, 8'h52);
    write_char(19, 8'h4C); write_char(20, 8'h44);
    log_q.delete(); done_cnt = 0;
    pulse_refresh();
    n_cmp++; if (active !== 1'b1 || data_ready !== 1'b0) begin n_fail++;
      $display("FAIL start_load: got active=%b dr=%b want 1/0", active, data_ready); end
    @(negedge clk);
    n_cmp++; if (data_ready !== 1'b1 || d_out !== 8'h80 || rs_out !== 1'b0) begin n_fail++;
      $display("FAIL start_req: got dr=%b d=%h rs=%b want 1/80/0", data_ready, d_out, rs_out); end
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL full_done_timeout: got none want done"); end
    repeat (3) @(negedge clk);
    n_cmp++; if (log_q.size() != 34) begin n_fail++; $display("FAIL full_count: got %0d want 34", log_q.size()); end
    else for (int j = 0; j < 34; j++) begin
      n_cmp++; if (log_q[j] !== exp_word(j)) begin n_fail++;
        $display("FAIL full_seq[%0d]: got %h want %h", j, log_q[j], exp_word(j)); end
    end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (active !== 1'b0) begin n_fail++; $display("FAIL full_idle_active: got %b want 0", active); end
  endtask

  task automatic test_collapse();
    bit ok1, ok2;
    log_q.delete(); done_cnt = 0;
    pulse_refresh();
    repeat (40) @(negedge clk); pulse_refresh();
    repeat (5)  @(negedge clk); pulse_refresh();
    repeat (5)  @(negedge clk); pulse_refresh();
    wait_done(ok1);
    wait_done(ok2);
    n_cmp++; if (ok1 !== 1'b1 || ok2 !== 1'b1) begin n_fail++; $display("FAIL collapse_done: got %b%b want 11", ok1, ok2); end
    repeat (200) @(negedge clk);
    n_cmp++; if (done_cnt != 2) begin n_fail++; $display("FAIL collapse_done_cnt: got %0d want 2", done_cnt); end
    n_cmp++; if (active !== 1'b0 || data_ready !== 1'b0) begin n_fail++;
      $display("FAIL collapse_idle: got active=%b dr=%b want 0/0", active, data_ready); end
    n_cmp++; if (log_q.size() != 68) begin n_fail++; $display("FAIL collapse_count: got %0d want 68", log_q.size()); end
    else for (int j = 0; j < 68; j++) begin
      n_cmp++; if (log_q[j] !== exp_word(j % 34)) begin n_fail++;
        $display("FAIL collapse_seq[%0d]: got %h want %h", j, log_q[j], exp_word(j % 34)); end
    end
  endtask

  task automatic test_collision();
    bit ok, found; int n;
    log_q.delete(); found = 1'b0; n = 0;
    pulse_refresh();
    while (!found && n < 500) begin
      if (log_q.size() == 3 && lcd_busy === 1'b0) found = 1'b1;
      else begin @(negedge clk); n++; end
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL coll_sync: got timeout want idx3 load"); end
    @(negedge clk);                 // sequencer now in LOAD for idx 3
    write_char(2, 8'h41);
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coll_done1: got none want done"); end
    n_cmp++; if (log_q.size() != 34 || log_q[3] !== 9'h14C) begin n_fail++;
      $display("FAIL coll_old_byte: got n=%0d b=%h want 34/14C", log_q.size(), log_q[3]); end
    repeat (3) @(negedge clk);
    log_q.delete();
    pulse_refresh();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coll_done2: got none want done"); end
    n_cmp++; if (log_q.size() != 34 || log_q[3] !== 9'h141) begin n_fail++;
      $display("FAIL coll_new_byte: got n=%0d b=%h want 34/141", log_q.size(), log_q[3]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok, found; int n;
    log_q.delete(); found = 1'b0; n = 0;
    pulse_refresh();
    repeat (30) @(negedge clk); pulse_refresh();   // leaves a pending repaint queued
    while (!found && n < 500) begin
      if (log_q.size() == 10 && data_ready === 1'b1 && lcd_busy === 1'b0) found = 1'b1;
      else begin @(negedge clk); n++; end
    end
    n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_sync: got timeout want REQ idx10"); end
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 32; i++) exp_buf[i] = 8'h20;
    n_cmp++; if (data_ready !== 1'b0 || active !== 1'b0 || d_out !== 8'h00) begin n_fail++;
      $display("FAIL rmid_outputs: got dr=%b act=%b d=%h want 0/0/00", data_ready, active, d_out); end
    repeat (60) @(negedge clk);
    n_cmp++; if (active !== 1'b0 || log_q.size() != 10) begin n_fail++;
      $display("FAIL rmid_no_resume: got act=%b n=%0d want 0/10", active, log_q.size()); end
    log_q.delete();
    pulse_refresh();
    wait_done(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_done: got none want done"); end
    n_cmp++; if (log_q.size() != 34) begin n_fail++; $display("FAIL rmid_count: got %0d want 34", log_q.size()); end
    else for (int j = 0; j < 34; j++) begin
      n_cmp++; if (log_q[j] !== exp_word(j)) begin n_fail++;
        $display("FAIL rmid_seq[%0d]: got %h want %h", j, log_q[j], exp_word(j)); end
    end
  endtask

  task automatic test_data_stability();
    n_cmp++; if (stab_samples == 0) begin n_fail++; $display("FAIL stab_samples: got 0 want >0"); end
    n_cmp++; if (stab_viol != 0) begin n_fail++; $display("FAIL stab_viol: got %0d want 0", stab_viol); end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; refresh = 1'b0; wr_addr = 5'd0; wr_data = 8'h00;
    test_reset();
    test_powerup();
    test_full_refresh();
    test_collapse();
    test_collision();
    test_reset_mid();
    test_data_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
